// File: rtl/mem_port_arbiter.sv
// Purpose : share one single-ported, variable-latency memory between instruction fetch and data load/store.
// Latency : request seen at an edge -> strobe after the next edge -> Done/Valid the edge after MemAck -> IDLE one cycle later.
// Backpr. : requesters hold their request until Done/Valid; the memory stalls the access by withholding MemAck, and a timeout bounds the stall.
//
// Ports: Clock/Reset (async, active-high); InstrReq/InstrAddr -> InstrIn/InstrValid (fetch side);
//        ReadData/WriteData/DataAddr/DataOut -> DataIn/DataDone (data side);
//        MemAddr/MemWData/MemRead/MemWrite/MemRData/MemAck (memory side); BusError, ProtoErr sticky flags.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int MEM_TIMEOUT  = 64,
    parameter int TO_BITS      = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 InstrReq,
    input  logic [WORD_SIZE-1:0] InstrAddr,
    output logic [WORD_SIZE-1:0] InstrIn,
    output logic                 InstrValid,
    input  logic                 ReadData,
    input  logic                 WriteData,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    output logic [WORD_SIZE-1:0] MemAddr,
    output logic [WORD_SIZE-1:0] MemWData,
    output logic                 MemRead,
    output logic                 MemWrite,
    input  logic [WORD_SIZE-1:0] MemRData,
    input  logic                 MemAck,
    output logic                 BusError,
    output logic                 ProtoErr
);

    localparam int SC_BITS = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DATA_ACC   = 3'd1,
        INSTR_ACC  = 3'd2,
        DATA_RESP  = 3'd3,
        INSTR_RESP = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [SC_BITS-1:0]   starve_cnt, starve_cnt_nxt;
    logic [TO_BITS-1:0]   to_cnt, to_cnt_nxt;

    logic [WORD_SIZE-1:0] mem_addr_nxt, mem_wdata_nxt, data_in_nxt, instr_in_nxt;
    logic                 mem_read_nxt, mem_write_nxt, data_done_nxt, instr_valid_nxt;
    logic                 bus_error_nxt, proto_err_nxt;

    logic dreq, force_instr, data_grant, instr_grant, in_acc, timeout, acc_done;

    assign dreq        = ReadData | WriteData;
    // A fetch that has waited through STARVE_LIMIT data grants wins over data.
    assign force_instr = InstrReq && (starve_cnt == SC_BITS'(STARVE_LIMIT));
    assign data_grant  = (state == IDLE) && dreq && !force_instr;
    assign instr_grant = (state == IDLE) && InstrReq && !(dreq && !force_instr);
    assign in_acc      = (state == DATA_ACC) || (state == INSTR_ACC);
    assign timeout     = in_acc && !MemAck && (to_cnt == TO_BITS'(MEM_TIMEOUT - 1));
    assign acc_done    = in_acc && (MemAck || timeout);

    // State and output registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            to_cnt     <= '0;
            MemAddr    <= '0;
            MemWData   <= '0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            DataIn     <= '0;
            InstrIn    <= '0;
            DataDone   <= 1'b0;
            InstrValid <= 1'b0;
            BusError   <= 1'b0;
            ProtoErr   <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            to_cnt     <= to_cnt_nxt;
            MemAddr    <= mem_addr_nxt;
            MemWData   <= mem_wdata_nxt;
            MemRead    <= mem_read_nxt;
            MemWrite   <= mem_write_nxt;
            DataIn     <= data_in_nxt;
            InstrIn    <= instr_in_nxt;
            DataDone   <= data_done_nxt;
            InstrValid <= instr_valid_nxt;
            BusError   <= bus_error_nxt;
            ProtoErr   <= proto_err_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (data_grant)       state_nxt = DATA_ACC;
                else if (instr_grant) state_nxt = INSTR_ACC;
            end
            DATA_ACC:   if (acc_done) state_nxt = DATA_RESP;
            INSTR_ACC:  if (acc_done) state_nxt = INSTR_RESP;
            DATA_RESP:  state_nxt = IDLE;
            INSTR_RESP: state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        mem_addr_nxt    = MemAddr;
        mem_wdata_nxt   = MemWData;
        mem_read_nxt    = MemRead;
        mem_write_nxt   = MemWrite;
        data_in_nxt     = DataIn;
        instr_in_nxt    = InstrIn;
        data_done_nxt   = 1'b0;
        instr_valid_nxt = 1'b0;
        bus_error_nxt   = BusError;
        proto_err_nxt   = ProtoErr;
        starve_cnt_nxt  = starve_cnt;
        to_cnt_nxt      = '0;

        if (data_grant) begin
            mem_addr_nxt  = DataAddr;
            mem_wdata_nxt = DataOut;
            // A simultaneous read+write performs only the write.
            mem_write_nxt = WriteData;
            mem_read_nxt  = !WriteData;
            if (ReadData && WriteData) proto_err_nxt = 1'b1;
            if (!InstrReq)
                starve_cnt_nxt = '0;
            else if (starve_cnt != SC_BITS'(STARVE_LIMIT))
                starve_cnt_nxt = starve_cnt + SC_BITS'(1);
        end

        if (instr_grant) begin
            mem_addr_nxt   = InstrAddr;
            mem_read_nxt   = 1'b1;
            starve_cnt_nxt = '0;
        end

        if (in_acc && !acc_done) to_cnt_nxt = to_cnt + TO_BITS'(1);

        if (acc_done) begin
            mem_read_nxt  = 1'b0;
            mem_write_nxt = 1'b0;
            if (timeout) bus_error_nxt = 1'b1;
            if (state == DATA_ACC) begin
                data_done_nxt = 1'b1;
                data_in_nxt   = (timeout || MemWrite) ? '0 : MemRData;
            end else begin
                instr_valid_nxt = 1'b1;
                instr_in_nxt    = timeout ? '0 : MemRData;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each step drives inputs 1 ns after a rising
// edge and checks the registered outputs at the same point, against hand-computed values.
module tb_mem_port_arbiter;

    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         InstrReq, ReadData, WriteData, MemAck;
    logic [W-1:0] InstrAddr, DataAddr, DataOut, MemRData;
    logic [W-1:0] InstrIn, DataIn, MemAddr, MemWData;
    logic         InstrValid, DataDone, MemRead, MemWrite, BusError, ProtoErr;

    int vectors     = 0;
    int miscompares = 0;

    mem_port_arbiter #(.WORD_SIZE(W), .STARVE_LIMIT(4), .MEM_TIMEOUT(64)) dut (
        .Clock(Clock), .Reset(Reset),
        .InstrReq(InstrReq), .InstrAddr(InstrAddr), .InstrIn(InstrIn), .InstrValid(InstrValid),
        .ReadData(ReadData), .WriteData(WriteData), .DataAddr(DataAddr), .DataOut(DataOut),
        .DataIn(DataIn), .DataDone(DataDone),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemRData(MemRData), .MemAck(MemAck), .BusError(BusError), .ProtoErr(ProtoErr)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_instr [10];
        int   n;
        exp_instr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        Reset = 1'b1; InstrReq = 0; ReadData = 0; WriteData = 0; MemAck = 0;
        InstrAddr = '0; DataAddr = '0; DataOut = '0; MemRData = '0;
        tick(); tick();

        // Reset state
        check("rst_memread",  MemRead, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_memaddr",  MemAddr, 0);
        check("rst_memwdata", MemWData, 0);
        check("rst_datadone", DataDone, 0);
        check("rst_ivalid",   InstrValid, 0);
        check("rst_datain",   DataIn, 0);
        check("rst_instrin",  InstrIn, 0);
        check("rst_buserr",   BusError, 0);
        check("rst_protoerr", ProtoErr, 0);
        Reset = 1'b0;
        tick();

        // Single load, MemAck in the second strobe cycle
        ReadData = 1; DataAddr = 16'h0010;
        tick();
        check("load_read_c1", MemRead, 1);
        check("load_addr_c1", MemAddr, 16'h0010);
        tick();
        check("load_read_c2", MemRead, 1);
        check("load_addr_c2", MemAddr, 16'h0010);
        MemAck = 1; MemRData = 16'hBEEF;
        tick();
        check("load_read_off", MemRead, 0);
        check("load_done",     DataDone, 1);
        check("load_datain",   DataIn, 16'hBEEF);
        MemAck = 0; ReadData = 0;
        tick();
        check("load_done_pulse", DataDone, 0);

        // Store, immediate ack; read data on the bus must not leak into DataIn
        WriteData = 1; DataAddr = 16'h0005; DataOut = 16'h1234;
        tick();
        check("store_write", MemWrite, 1);
        check("store_read",  MemRead, 0);
        check("store_addr",  MemAddr, 16'h0005);
        check("store_wdata", MemWData, 16'h1234);
        MemAck = 1; MemRData = 16'hFFFF;
        tick();
        check("store_write_off", MemWrite, 0);
        check("store_done",      DataDone, 1);
        check("store_datain",    DataIn, 0);
        MemAck = 0; WriteData = 0;
        tick();
        check("store_done_pulse", DataDone, 0);

        // Simultaneous requests with starve_cnt=0: data first, then fetch
        InstrReq = 1; InstrAddr = 16'h0100; ReadData = 1; DataAddr = 16'h0020;
        MemAck = 1; MemRData = 16'h1111;
        tick();
        check("sim_data_first", MemAddr, 16'h0020);
        tick();
        check("sim_ddone",  DataDone, 1);
        check("sim_datain", DataIn, 16'h1111);
        check("sim_no_iv",  InstrValid, 0);
        ReadData = 0; MemRData = 16'h2222;
        tick();
        check("sim_idle_read", MemRead, 0);
        tick();
        check("sim_fetch_read", MemRead, 1);
        check("sim_fetch_addr", MemAddr, 16'h0100);
        tick();
        check("sim_ivalid",  InstrValid, 1);
        check("sim_instrin", InstrIn, 16'h2222);
        InstrReq = 0;
        tick();

        // Contention: D,D,D,D,I,D,D,D,D,I, one completion every 3 cycles
        InstrReq = 1; InstrAddr = 16'h0040; ReadData = 1; DataAddr = 16'h0030;
        MemAck = 1; MemRData = 16'h5555;
        for (int k = 0; k < 10; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!(DataDone || InstrValid) && n < 10);
            check("cont_completion", DataDone | InstrValid, 1);
            check("cont_kind_instr", InstrValid, exp_instr[k]);
            if (k > 0) check("cont_period", n, 3);
        end
        InstrReq = 0; ReadData = 0; MemAck = 0;
        tick();
        tick();

        // Timeout: no MemAck
        ReadData = 1; DataAddr = 16'h0077; MemRData = 16'hABCD;
        tick();
        check("to_buserr_before", BusError, 0);
        n = 0;
        while (MemRead && n < 100) begin
            n++;
            tick();
        end
        check("to_read_cycles", n, 64);
        check("to_buserr",  BusError, 1);
        check("to_done",    DataDone, 1);
        check("to_datain",  DataIn, 0);
        ReadData = 0;
        tick();
        check("to_done_pulse", DataDone, 0);
        check("to_buserr_sticky", BusError, 1);

        // Read+write together: write only, ProtoErr set
        ReadData = 1; WriteData = 1; DataAddr = 16'h0009; DataOut = 16'h00AA; MemAck = 1;
        tick();
        check("pe_write",  MemWrite, 1);
        check("pe_read",   MemRead, 0);
        check("pe_flag",   ProtoErr, 1);
        tick();
        check("pe_done",   DataDone, 1);
        ReadData = 0; WriteData = 0; MemAck = 0;
        tick();

        // Reset during INSTR_ACC
        InstrReq = 1; InstrAddr = 16'h0200;
        tick();
        check("rstacc_read", MemRead, 1);
        Reset = 1;
        #1;
        check("rstacc_read_async", MemRead, 0);
        check("rstacc_buserr_clr", BusError, 0);
        check("rstacc_protoerr_clr", ProtoErr, 0);
        tick();
        check("rstacc_no_ivalid", InstrValid, 0);
        Reset = 0;
        tick();
        check("rstacc_fresh_read", MemRead, 1);
        check("rstacc_fresh_addr", MemAddr, 16'h0200);
        MemAck = 1; MemRData = 16'h3C3C;
        tick();
        check("rstacc_ivalid",  InstrValid, 1);
        check("rstacc_instrin", InstrIn, 16'h3C3C);
        InstrReq = 0; MemAck = 0;
        tick();
        check("rstacc_ivalid_pulse", InstrValid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
